serial_echo_ctrl: RTL and testbench

Controller that sits between the serial receiver and the serial transmitter of the echo path. It queues every byte the receiver reports in an internal FIFO and sequences the transmitter one byte at a time using a start/busy handshake. It flags bytes lost to FIFO overflow, and can optionally append LF after each echoed CR.

---
 rtl/serial_echo_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_echo_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_echo_ctrl.sv
// Echo-path controller: queues received words in a circular FIFO and feeds the transmitter one word per start/busy handshake.
// Optional CR->CRLF expansion is enabled by defining SERIAL_ECHO_CRLF_EN.
module serial_echo_ctrl #(
  parameter int NUM_BITS   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BITS-1:0]           rx_data,
  input  logic                          rx_valid,
  input  logic                          tx_busy,
  input  logic                          clear_overflow,
  output logic [NUM_BITS-1:0]           tx_data,
  output logic                          tx_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3
`ifdef SERIAL_ECHO_CRLF_EN
    , S_LF      = 3'd4
`endif
  } state_t;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("serial_echo_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end
`ifdef SERIAL_ECHO_CRLF_EN
    if (NUM_BITS != 8) begin : g_width_chk
      $error("serial_echo_ctrl: CRLF expansion requires NUM_BITS == 8");
    end
`endif
  endgenerate

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [NUM_BITS-1:0] r_tx_data;
  logic                r_overflow;

  logic w_full;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped.
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_push = rx_valid && !w_full;
  assign w_drop = rx_valid && w_full;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (r_count != '0) w_state_next = S_START;
      S_START:     w_state_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (tx_busy) w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef SERIAL_ECHO_CRLF_EN
          // An inserted LF leaves 8'h0A in tx_data, so it can never re-trigger this.
          if (r_tx_data == NUM_BITS'(8'h0D)) w_state_next = S_LF;
          else                               w_state_next = S_IDLE;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef SERIAL_ECHO_CRLF_EN
      S_LF:        w_state_next = S_START;
`endif
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Storage has no reset so it maps onto block RAM; reset empties it via the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
`ifdef SERIAL_ECHO_CRLF_EN
      else if (r_state == S_LF) begin
        r_tx_data <= NUM_BITS'(8'h0A);
      end
`endif
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign tx_start   = (r_state == S_START);
  assign tx_data    = r_tx_data;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_echo_ctrl.sv
// Directed bench for serial_echo_ctrl with a behavioural transmitter that raises busy one cycle after each start.
// Expected CRLF behaviour follows SERIAL_ECHO_CRLF_EN at compile time.
module tb_serial_echo_ctrl;

  localparam int BUSY_LEN = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       clear_overflow;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [4:0] fifo_count;
  logic       overflow;

  logic       model_busy;
  logic       hold_busy;
  int         busy_cnt;
  logic       prev_start;
  int         wide_cnt;
  logic [7:0] sent [$];

  int n_vectors;
  int n_miscompares;

  serial_echo_ctrl #(.NUM_BITS(8), .FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_busy        (tx_busy),
    .clear_overflow (clear_overflow),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = model_busy | hold_busy;

  // Transmitter model: logs each started word and holds busy for BUSY_LEN cycles.
  always @(negedge clk) begin
    if (tx_start) begin
      sent.push_back(tx_data);
      if (prev_start) wide_cnt++;
      busy_cnt   = BUSY_LEN;
      model_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
    prev_start = tx_start;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s = %0h", tag, act);
    end
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_sent(input int n, input string tag);
    int t;
    t = 0;
    while (sent.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    chk(tag, sent.size(), n);
  endtask

  initial begin
    int base;
    int max_cnt;
    model_busy     = 1'b0;
    hold_busy      = 1'b0;
    busy_cnt       = 0;
    prev_start     = 1'b0;
    wide_cnt       = 0;
    n_vectors      = 0;
    n_miscompares  = 0;
    rx_data        = '0;
    rx_valid       = 1'b0;
    clear_overflow = 1'b0;
    rst_n          = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);

    // Single word latency
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("lat_c1_count", fifo_count, 1);
    chk("lat_c1_start", tx_start, 0);
    @(negedge clk);
    chk("lat_c2_start", tx_start, 1);
    chk("lat_c2_data", tx_data, 8'h41);
    chk("lat_c2_count", fifo_count, 0);
    @(negedge clk);
    chk("lat_c3_start", tx_start, 0);
    wait_sent(1, "lat_nsent");
    chk("lat_word", sent[0], 8'h41);
    chk("lat_overflow", overflow, 0);

    // Fill 16 while busy held
    sent.delete();
    hold_busy = 1'b1;
    max_cnt   = 0;
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    chk("fill_count", fifo_count, 15);
    chk("fill_peak", max_cnt, 15);
    chk("fill_nsent", sent.size(), 1);
    chk("fill_first", sent[0], 8'h00);
    hold_busy = 1'b0;
    wait_sent(16, "fill_nsent_all");
    for (int i = 0; i < 16; i++) chk($sformatf("fill_w%0d", i), sent[i], i);

    // Overflow, sticky flag and clear priority
    sent.delete();
    hold_busy = 1'b1;
    push(8'hEE);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    chk("ovf_full_count", fifo_count, 16);
    chk("ovf_before_drop", overflow, 0);
    push(8'h30);
    chk("ovf_set", overflow, 1);
    chk("ovf_count_kept", fifo_count, 16);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);
    clear_overflow = 1'b1;
    push(8'h31);
    clear_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    push(8'h32);
    push(8'h33);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("ovf_cleared2", overflow, 0);
    hold_busy = 1'b0;
    wait_sent(17, "ovf_nsent");
    chk("ovf_w0", sent[0], 8'hEE);
    for (int i = 0; i < 16; i++) chk($sformatf("ovf_w%0d", i + 1), sent[i + 1], 8'h20 + i);

    // Simultaneous push and pop at count 3
    sent.delete();
    hold_busy = 1'b1;
    push(8'h50);
    push(8'h51);
    push(8'h52);
    push(8'h53);
    repeat (25) @(negedge clk);
    chk("pp_before", fifo_count, 3);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("pp_idle_count", fifo_count, 3);
    push(8'h54);
    chk("pp_after", fifo_count, 3);
    wait_sent(5, "pp_nsent");
    for (int i = 0; i < 5; i++) chk($sformatf("pp_w%0d", i), sent[i], 8'h50 + i);

    // Pointer wrap: 40 words in bursts of 10
    sent.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push(8'h80 + 8'(b * 10 + i));
      wait_sent(10 * (b + 1), $sformatf("wrap_nsent_b%0d", b));
    end
    for (int i = 0; i < 40; i++) chk($sformatf("wrap_w%0d", i), sent[i], 8'h80 + i);

    // Reset in WAIT_DONE with 5 queued
    sent.delete();
    hold_busy = 1'b1;
    push(8'h60);
    for (int i = 1; i <= 5; i++) push(8'h60 + 8'(i));
    repeat (3) @(negedge clk);
    chk("mrst_queued", fifo_count, 5);
    rst_n = 1'b0;
    #1;
    chk("mrst_count", fifo_count, 0);
    chk("mrst_tx_data", tx_data, 0);
    chk("mrst_tx_start", tx_start, 0);
    chk("mrst_overflow", overflow, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    hold_busy = 1'b0;
    base      = sent.size();
    repeat (40) @(negedge clk);
    chk("mrst_no_start", sent.size(), base);
    push(8'h70);
    wait_sent(base + 1, "mrst_nsent");
    chk("mrst_new_word", sent[base], 8'h70);

    // CR handling
    sent.delete();
    push(8'h0D);
    push(8'h41);
`ifdef SERIAL_ECHO_CRLF_EN
    wait_sent(3, "crlf_nsent");
    chk("crlf_w0", sent[0], 8'h0D);
    chk("crlf_w1", sent[1], 8'h0A);
    chk("crlf_w2", sent[2], 8'h41);
`else
    wait_sent(2, "crlf_nsent");
    chk("crlf_w0", sent[0], 8'h0D);
    chk("crlf_w1", sent[1], 8'h41);
`endif
    chk("start_width", wide_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
